// File: rtl/util_axis_uart.sv
// AXI-Stream to UART bridge: independent TX and RX engines sharing one bit-period definition.
// RX input is synchronised, then frames are checked for parity/stop errors before delivery.
module util_axis_uart #(
  parameter int unsigned baud_clock_speed = 2000000,
  parameter int unsigned baud_rate        = 115200,
  parameter int unsigned parity_ena       = 0,
  parameter int unsigned parity_type      = 0,
  parameter int unsigned stop_bits        = 1,
  parameter int unsigned data_bits        = 8,
  parameter int unsigned rx_delay         = 0
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic [data_bits-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [data_bits-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 tx,
  input  logic                 rx
);

  localparam int unsigned BP   = baud_clock_speed / baud_rate;
  localparam int unsigned HALF = ((BP / 2) > 0) ? (BP / 2) : 1;
  localparam int unsigned CW   = (BP > 1) ? $clog2(BP) : 1;
  localparam int unsigned IW   = $clog2((data_bits > stop_bits) ? data_bits : stop_bits);
  localparam int unsigned SL   = 2 + rx_delay;

  localparam logic [CW-1:0] BP_LAST   = CW'(BP - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(data_bits - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(stop_bits - 1);
  localparam logic          PAR_ENA   = (parity_ena != 0);
  localparam logic          PAR_ODD   = (parity_type != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------- transmitter ----------------
  state_t                 tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]          tx_idx_q, tx_idx_d;
  logic [data_bits-1:0]   tx_shreg_q, tx_shreg_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;
  logic                   s_tready_q, s_tready_d;
  logic                   tx_bit_end;

  assign tx_bit_end    = (tx_cnt_q == BP_LAST);
  assign s_axis_tready = s_tready_q;
  assign tx            = tx_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      s_tready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      s_tready_q <= s_tready_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    s_tready_d = s_tready_q;

    if (tx_state_q != ST_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
    end

    case (tx_state_q)
      ST_IDLE: begin
        tx_d       = 1'b1;
        s_tready_d = 1'b1;
        if (s_axis_tvalid && s_tready_q) begin
          tx_state_d = ST_START;
          tx_shreg_d = s_axis_tdata;
          tx_par_d   = (^s_axis_tdata) ^ PAR_ODD;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          s_tready_d = 1'b0;
        end
      end
      ST_START: begin
        if (tx_bit_end) begin
          tx_state_d = ST_DATA;
          tx_idx_d   = '0;
          tx_d       = tx_shreg_q[0];
        end
      end
      ST_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_d = '0;
            if (PAR_ENA) begin
              tx_state_d = ST_PARITY;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = ST_STOP;
              tx_d       = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + IW'(1);
            tx_shreg_d = tx_shreg_q >> 1;
            tx_d       = tx_shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = ST_STOP;
          tx_idx_d   = '0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx_q == STOP_LAST) begin
            tx_state_d = ST_IDLE;
            s_tready_d = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + IW'(1);
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic [SL-1:0]          sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  state_t                 rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [IW-1:0]          rx_idx_q, rx_idx_d;
  logic [data_bits-1:0]   rx_shreg_q, rx_shreg_d;
  logic                   rx_err_q, rx_err_d;
  logic [data_bits-1:0]   m_tdata_q, m_tdata_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   rx_s;
  logic                   rx_bit_end;
  logic                   rx_accept;

  assign rx_s          = sync_q[SL-1];
  assign rx_bit_end    = (rx_cnt_q == BP_LAST);
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shreg_q <= '0;
      rx_err_q   <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shreg_q <= rx_shreg_d;
      rx_err_q   <= rx_err_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  // Frame decode; all data/parity/stop samples land mid-bit, BP cycles after the half-bit start check.
  always_comb begin
    sync_d     = {sync_q[SL-2:0], rx};
    rx_prev_d  = rx_s;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shreg_d = rx_shreg_q;
    rx_err_d   = rx_err_q;
    rx_accept  = 1'b0;

    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        rx_err_d = 1'b0;
        if (rx_prev_q && !rx_s) begin
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_s, rx_shreg_q[data_bits-1:1]};
          if (rx_idx_q == DATA_LAST) begin
            rx_idx_d   = '0;
            rx_state_d = PAR_ENA ? ST_PARITY : ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_STOP;
          if (rx_s != ((^rx_shreg_q) ^ PAR_ODD)) begin
            rx_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          if (!rx_s) begin
            rx_err_d = 1'b1;
          end
          if (rx_idx_q == STOP_LAST) begin
            rx_state_d = ST_IDLE;
            rx_accept  = !rx_err_q && rx_s;
          end else begin
            rx_idx_d = rx_idx_q + IW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // Output holding register: a new byte only replaces one that is free or leaving this cycle.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
    if (rx_accept && (!m_tvalid_q || m_axis_tready)) begin
      m_tdata_d  = rx_shreg_q;
      m_tvalid_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_util_axis_uart.sv
// Directed bench for util_axis_uart at 10 MHz / 115200 baud, odd parity, 1 stop bit (BP = 86).
module tb_util_axis_uart;

  localparam int BP = 86;

  logic       aclk;
  logic       arst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       tx;
  logic       rx;
  logic       rx_drv;
  logic       loop_en;

  int n_checks;
  int n_fail;
  int hs_cnt;
  logic [7:0] hs_data;
  logic valid_seen;

  assign rx = loop_en ? tx : rx_drv;

  util_axis_uart #(
    .baud_clock_speed(10000000),
    .baud_rate       (115200),
    .parity_ena      (1),
    .parity_type     (1),
    .stop_bits       (1),
    .data_bits       (8),
    .rx_delay        (0)
  ) dut (
    .aclk         (aclk),
    .arst         (arst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .tx           (tx),
    .rx           (rx)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling the RX output stream 1 time unit after each edge.
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      if (m_tvalid) valid_seen = 1'b1;
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        hs_data = m_tdata;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx_drv = 1'b0;
    wait_cycles(BP);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      wait_cycles(BP);
    end
    rx_drv = par;
    wait_cycles(BP);
    rx_drv = stop;
    wait_cycles(BP);
    rx_drv = 1'b1;
  endtask

  task automatic clear_mon();
    hs_cnt     = 0;
    hs_data    = 8'h00;
    valid_seen = 1'b0;
  endtask

  initial begin
    logic [10:0] exp_tx;
    logic        pend;
    int          cyc;
    int          n_rx;
    int          last_cyc;
    int          gap;

    n_checks = 0;
    n_fail   = 0;
    aclk     = 1'b0;
    arst     = 1'b1;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;
    clear_mon();

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_tx", 32'(tx), 32'h1);
    check_eq("rst_tready", 32'(s_tready), 32'h0);
    check_eq("rst_mvalid", 32'(m_tvalid), 32'h0);
    check_eq("rst_mdata", 32'(m_tdata), 32'h0);
    arst = 1'b0;
    @(posedge aclk);
    #1;
    check_eq("rst_release_tready", 32'(s_tready), 32'h1);

    // single TX frame of 0x41: start, 1000_0010 LSB first, odd parity 1, stop
    exp_tx   = 11'b11010000010;
    s_tdata  = 8'h41;
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    check_eq("tx_xfer_tready", 32'(s_tready), 32'h0);
    check_eq("tx_start_first", 32'(tx), 32'h0);
    for (int k = 0; k < 11; k++) begin
      repeat (43) @(posedge aclk);
      #1;
      check_eq($sformatf("tx_bit%0d", k), 32'(tx), 32'(exp_tx[k]));
      if (k < 10) repeat (43) @(posedge aclk);
      else repeat (42) @(posedge aclk);
    end
    #1;
    check_eq("tx_stop_end_tready", 32'(s_tready), 32'h0);
    @(posedge aclk);
    #1;
    check_eq("tx_idle_tready", 32'(s_tready), 32'h1);
    check_eq("tx_idle_line", 32'(tx), 32'h1);

    // loopback stream 0x41, 0x42, ... with tvalid held
    loop_en  = 1'b1;
    m_tready = 1'b1;
    s_tdata  = 8'h41;
    s_tvalid = 1'b1;
    pend     = s_tready;
    cyc      = 0;
    n_rx     = 0;
    last_cyc = 0;
    while (n_rx < 4 && cyc < 6000) begin
      @(posedge aclk);
      #1;
      cyc++;
      if (pend) s_tdata = s_tdata + 8'd1;
      pend = s_tvalid && s_tready;
      if (m_tvalid) begin
        check_eq($sformatf("loop_byte%0d", n_rx), 32'(m_tdata), 32'h41 + 32'(n_rx));
        if (n_rx > 0) begin
          gap = cyc - last_cyc;
          check_eq("loop_interval", 32'(gap >= 946 && gap <= 947), 32'h1);
        end
        last_cyc = cyc;
        n_rx++;
      end
    end
    check_eq("loop_count", 32'(n_rx), 32'd4);
    s_tvalid = 1'b0;
    wait_cycles(1200);
    loop_en = 1'b0;

    // bad parity is dropped, following good frame delivered
    clear_mon();
    send_frame(8'h41, 1'b0, 1'b1);
    wait_cycles(100);
    check_eq("bad_parity_no_valid", 32'(valid_seen), 32'h0);
    send_frame(8'h42, 1'b1, 1'b1);
    wait_cycles(50);
    check_eq("after_bad_count", 32'(hs_cnt), 32'd1);
    check_eq("after_bad_data", 32'(hs_data), 32'h42);

    // stop bit sampled low is dropped
    clear_mon();
    send_frame(8'h41, 1'b1, 1'b0);
    wait_cycles(100);
    check_eq("bad_stop_no_valid", 32'(valid_seen), 32'h0);

    // 20-cycle glitch rejected, receiver still ready for a real frame
    clear_mon();
    rx_drv = 1'b0;
    wait_cycles(20);
    rx_drv = 1'b1;
    wait_cycles(300);
    check_eq("glitch_no_valid", 32'(valid_seen), 32'h0);
    send_frame(8'h55, 1'b1, 1'b1);
    wait_cycles(50);
    check_eq("post_glitch_count", 32'(hs_cnt), 32'd1);
    check_eq("post_glitch_data", 32'(hs_data), 32'h55);

    // backpressure: first byte held, second dropped
    clear_mon();
    m_tready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    wait_cycles(50);
    check_eq("hold_valid", 32'(m_tvalid), 32'h1);
    check_eq("hold_data", 32'(m_tdata), 32'h11);
    send_frame(8'h22, 1'b1, 1'b1);
    wait_cycles(50);
    check_eq("hold2_valid", 32'(m_tvalid), 32'h1);
    check_eq("hold2_data", 32'(m_tdata), 32'h11);
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
    check_eq("release_valid", 32'(m_tvalid), 32'h0);
    m_tready = 1'b1;

    // reset in the middle of a looped-back frame
    clear_mon();
    loop_en  = 1'b1;
    s_tdata  = 8'h5A;
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    wait_cycles(300);
    arst = 1'b1;
    @(posedge aclk);
    #1;
    check_eq("midrst_tx", 32'(tx), 32'h1);
    check_eq("midrst_tready", 32'(s_tready), 32'h0);
    check_eq("midrst_mvalid", 32'(m_tvalid), 32'h0);
    repeat (2) @(posedge aclk);
    #1;
    arst = 1'b0;
    @(posedge aclk);
    #1;
    check_eq("midrst_release_tready", 32'(s_tready), 32'h1);
    check_eq("midrst_release_tx", 32'(tx), 32'h1);
    clear_mon();
    wait_cycles(1200);
    check_eq("midrst_no_partial", 32'(valid_seen), 32'h0);
    loop_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
